// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss-handling sequencer for the 4-way set-associative cache.
// On a miss it writes back a dirty victim, then fetches the missing line over a
// req/ack handshake and hands it to the cache as a one-cycle fill pulse.
// Optional statistics counters are built when CACHE_MISS_CTRL_STATS_EN is defined;
// otherwise o_miss_count and o_wb_count are tied to zero.
module cache_miss_ctrl #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TAG_BITS       = 18,
    parameter int INDEX_BITS     = 8,
    parameter int OFFSET_BITS    = 6,
    parameter int LINE_SIZE_BITS = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_miss,
    input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
    input  logic                      i_victim_valid,
    input  logic                      i_victim_dirty,
    input  logic [TAG_BITS-1:0]       i_victim_tag,
    input  logic [LINE_SIZE_BITS-1:0] i_victim_data,
    output logic                      o_fill_valid,
    output logic [LINE_SIZE_BITS-1:0] o_fill_line,
    output logic                      o_busy,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
    output logic [LINE_SIZE_BITS-1:0] o_mem_wdata,
    input  logic                      i_mem_ack,
    input  logic [LINE_SIZE_BITS-1:0] i_mem_rdata,
    output logic                      o_err,
    output logic [15:0]               o_miss_count,
    output logic [15:0]               o_wb_count
);

    localparam int LINE_ADDR_BITS = TAG_BITS + INDEX_BITS;
    localparam int TIMER_BITS     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FETCH     = 2'd2;
    localparam logic [1:0] ST_DELIVER   = 2'd3;

    generate
        if (ADDRESS_WIDTH != TAG_BITS + INDEX_BITS + OFFSET_BITS) begin : g_bad_width
            $error("cache_miss_ctrl: ADDRESS_WIDTH must equal TAG_BITS+INDEX_BITS+OFFSET_BITS");
        end
    endgenerate

    logic [1:0]                state_q, state_d;
    logic [TIMER_BITS-1:0]     timer_q, timer_d;
    logic [LINE_ADDR_BITS-1:0] lineAddr_q;
    logic [TAG_BITS-1:0]       victimTag_q;
    logic [LINE_SIZE_BITS-1:0] victimData_q;
    logic [LINE_SIZE_BITS-1:0] fillLine_q;
    logic                      fillValid_q;
    logic                      err_q;
    logic                      inRequest;
    logic                      timeout;
    logic                      capture;
    logic                      unused_offset;

    assign unused_offset = ^i_miss_addr[OFFSET_BITS-1:0];

    assign inRequest = (state_q == ST_WRITEBACK) || (state_q == ST_FETCH);
    assign timeout   = inRequest && !i_mem_ack && (timer_q == TIMER_LAST);
    assign capture   = (state_q == ST_IDLE) && i_miss;

    // Next-state decode: an ack always wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_miss) begin
                    state_d = (i_victim_valid && i_victim_dirty) ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                if (i_mem_ack) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (i_mem_ack) begin
                    state_d = ST_DELIVER;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request timer restarts whenever a request phase is entered or left.
    always_comb begin
        timer_d = '0;
        if (inRequest && (state_d == state_q)) begin
            timer_d = timer_q + TIMER_BITS'(1);
        end
    end

    // State, timer and the miss/victim capture registers frozen for the whole sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            lineAddr_q   <= '0;
            victimTag_q  <= '0;
            victimData_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (capture) begin
                lineAddr_q   <= i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS];
                victimTag_q  <= i_victim_tag;
                victimData_q <= i_victim_data;
            end
        end
    end

    // Registered cache-side outputs: fill line/pulse on the fetch ack, error pulse on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fillLine_q  <= '0;
            fillValid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if ((state_q == ST_FETCH) && i_mem_ack) begin
                fillLine_q <= i_mem_rdata;
            end
            fillValid_q <= (state_q == ST_FETCH) && i_mem_ack;
            err_q       <= timeout;
        end
    end

    assign o_fill_valid = fillValid_q;
    assign o_fill_line  = fillLine_q;
    assign o_err        = err_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_mem_req    = inRequest;
    assign o_mem_we     = (state_q == ST_WRITEBACK);

    // Memory address and write data decode straight from the state and capture registers.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (state_q == ST_WRITEBACK) begin
            o_mem_addr  = {victimTag_q, lineAddr_q[INDEX_BITS-1:0], {OFFSET_BITS{1'b0}}};
            o_mem_wdata = victimData_q;
        end else if (state_q == ST_FETCH) begin
            o_mem_addr  = {lineAddr_q, {OFFSET_BITS{1'b0}}};
        end
    end

`ifdef CACHE_MISS_CTRL_STATS_EN
    logic [15:0] missCount_q;
    logic [15:0] wbCount_q;

    // Saturating counts of delivered fills and acknowledged writebacks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            missCount_q <= '0;
            wbCount_q   <= '0;
        end else begin
            if ((state_q == ST_DELIVER) && (missCount_q != 16'hFFFF)) begin
                missCount_q <= missCount_q + 16'd1;
            end
            if ((state_q == ST_WRITEBACK) && i_mem_ack && (wbCount_q != 16'hFFFF)) begin
                wbCount_q <= wbCount_q + 16'd1;
            end
        end
    end

    assign o_miss_count = missCount_q;
    assign o_wb_count   = wbCount_q;
`else
    assign o_miss_count = 16'd0;
    assign o_wb_count   = 16'd0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed scoreboard bench for cache_miss_ctrl.
// Expected memory requests and fill lines are queued as stimulus is driven and
// popped when the controller presents them.
module tb_cache_miss_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [31:0] i_miss_addr;
    logic        i_victim_valid;
    logic        i_victim_dirty;
    logic [17:0] i_victim_tag;
    logic [31:0] i_victim_data;
    logic        o_fill_valid;
    logic [31:0] o_fill_line;
    logic        o_busy;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_err;
    logic [15:0] o_miss_count;
    logic [15:0] o_wb_count;

    int          assertCount;
    int          failCount;
    req_t        reqQ[$];
    logic [31:0] fillQ[$];

    cache_miss_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .i_victim_valid (i_victim_valid),
        .i_victim_dirty (i_victim_dirty),
        .i_victim_tag   (i_victim_tag),
        .i_victim_data  (i_victim_data),
        .o_fill_valid   (o_fill_valid),
        .o_fill_line    (o_fill_line),
        .o_busy         (o_busy),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata),
        .o_err          (o_err),
        .o_miss_count   (o_miss_count),
        .o_wb_count     (o_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lineAddr(input logic [31:0] addr);
        return {addr[31:6], 6'b0};
    endfunction

    function automatic logic [31:0] wbAddr(input logic [17:0] tag, input logic [31:0] addr);
        return {tag, addr[13:6], 6'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic valid, input logic dirty,
                                 input logic [17:0] tag, input logic [31:0] data);
        i_miss         = 1'b1;
        i_miss_addr    = addr;
        i_victim_valid = valid;
        i_victim_dirty = dirty;
        i_victim_tag   = tag;
        i_victim_data  = data;
        if (valid && dirty) begin
            reqQ.push_back('{we: 1'b1, addr: wbAddr(tag, addr), wdata: data});
        end
        reqQ.push_back('{we: 1'b0, addr: lineAddr(addr), wdata: 32'h0});
    endtask

    task automatic expectRequest(input string tag, input int budget, output int waited);
        req_t expReq;
        waited = 0;
        while (o_mem_req !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_req"}, 64'(o_mem_req), 64'd1);
        assertCount++;
        assert (reqQ.size() != 0) else begin
            failCount++;
            $error("[TB] FAIL %s_queue: observed empty request queue, required one entry", tag);
        end
        if (reqQ.size() != 0) begin
            expReq = reqQ.pop_front();
            checkOutput({tag, "_we"}, 64'(o_mem_we), 64'(expReq.we));
            checkOutput({tag, "_addr"}, 64'(o_mem_addr), 64'(expReq.addr));
            if (expReq.we) begin
                checkOutput({tag, "_wdata"}, 64'(o_mem_wdata), 64'(expReq.wdata));
            end
        end
    endtask

    task automatic serveAck(input int delay, input logic [31:0] rdata, input logic isRead);
        repeat (delay) @(negedge clk);
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
        if (isRead) begin
            fillQ.push_back(rdata);
        end
        @(negedge clk);
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
    endtask

    task automatic expectFill(input string tag, input int budget);
        int          waited;
        logic [31:0] expLine;
        waited = 0;
        while (o_fill_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_fill_valid"}, 64'(o_fill_valid), 64'd1);
        expLine = (fillQ.size() != 0) ? fillQ.pop_front() : 32'hxxxx_xxxx;
        checkOutput({tag, "_fill_line"}, 64'(o_fill_line), 64'(expLine));
    endtask

    task automatic checkCounters(input string tag, input int expMiss, input int expWb);
`ifdef CACHE_MISS_CTRL_STATS_EN
        checkOutput({tag, "_miss_count"}, 64'(o_miss_count), 64'(expMiss));
        checkOutput({tag, "_wb_count"}, 64'(o_wb_count), 64'(expWb));
`else
        checkOutput({tag, "_miss_count"}, 64'(o_miss_count), 64'(expMiss * 0));
        checkOutput({tag, "_wb_count"}, 64'(o_wb_count), 64'(expWb * 0));
`endif
    endtask

    initial begin
        int waited;
        int highCycles;
        int errEarly;
        int fillSeen;
        assertCount    = 0;
        failCount      = 0;
        rst            = 1'b1;
        i_miss         = 1'b0;
        i_miss_addr    = 32'h0;
        i_victim_valid = 1'b0;
        i_victim_dirty = 1'b0;
        i_victim_tag   = 18'h0;
        i_victim_data  = 32'h0;
        i_mem_ack      = 1'b0;
        i_mem_rdata    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_req", 64'(o_mem_req), 64'd0);
        checkOutput("reset_busy", 64'(o_busy), 64'd0);
        checkOutput("reset_fill_valid", 64'(o_fill_valid), 64'd0);
        checkOutput("reset_fill_line", 64'(o_fill_line), 64'd0);
        checkOutput("reset_err", 64'(o_err), 64'd0);
        checkCounters("reset", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean miss: valid but clean victim, ack three cycles after request
        applyStimulus(32'h0001_2340, 1'b1, 1'b0, 18'h3, 32'h0BAD_0BAD);
        expectRequest("clean", 5, waited);
        checkOutput("clean_latency", 64'(waited), 64'd1);
        serveAck(3, 32'hDEAD_BEEF, 1'b1);
        expectFill("clean", 5);
        i_miss = 1'b0;
        @(negedge clk);
        checkOutput("clean_fill_pulse", 64'(o_fill_valid), 64'd0);
        checkOutput("clean_busy_low", 64'(o_busy), 64'd0);

        // Dirty miss: writeback then fetch with request held across the edge
        applyStimulus(32'h0001_2340, 1'b1, 1'b1, 18'h00005, 32'h1234_5678);
        expectRequest("dirty_wb", 5, waited);
        serveAck(0, 32'h5555_AAAA, 1'b0);
        expectRequest("dirty_fetch", 0, waited);
        checkOutput("dirty_req_continuous", 64'(waited), 64'd0);
        serveAck(1, 32'hCAFE_F00D, 1'b1);
        expectFill("dirty", 5);
        i_miss = 1'b0;
        @(negedge clk);
        checkOutput("dirty_busy_low", 64'(o_busy), 64'd0);
        checkCounters("dirty", 2, 1);

        // Timeout on writeback, retried from IDLE while the miss stays high
        applyStimulus(32'h00AB_CDC0, 1'b1, 1'b1, 18'h2A5, 32'hA5A5_5A5A);
        expectRequest("timeout_first", 5, waited);
        reqQ.push_front('{we: 1'b1, addr: wbAddr(18'h2A5, 32'h00AB_CDC0), wdata: 32'hA5A5_5A5A});
        highCycles = 0;
        errEarly   = 0;
        for (int i = 0; i < 400; i++) begin
            if (o_mem_req !== 1'b1) break;
            highCycles++;
            if (o_err === 1'b1) errEarly++;
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", 64'(highCycles), 64'd255);
        checkOutput("timeout_err_early", 64'(errEarly), 64'd0);
        checkOutput("timeout_err_pulse", 64'(o_err), 64'd1);
        checkOutput("timeout_req_low", 64'(o_mem_req), 64'd0);
        @(negedge clk);
        checkOutput("timeout_err_once", 64'(o_err), 64'd0);
        expectRequest("timeout_retry_wb", 0, waited);
        serveAck(0, 32'h0, 1'b0);
        expectRequest("timeout_retry_fetch", 0, waited);
        serveAck(2, 32'h7777_1234, 1'b1);
        expectFill("timeout", 5);
        i_miss = 1'b0;
        @(negedge clk);
        checkOutput("timeout_busy_low", 64'(o_busy), 64'd0);
        checkCounters("timeout", 3, 2);

        // Reset asserted mid-fetch drops the request immediately
        applyStimulus(32'h00FF_0040, 1'b0, 1'b1, 18'h1, 32'h1);
        expectRequest("rst_fetch", 5, waited);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_req_async", 64'(o_mem_req), 64'd0);
        checkOutput("rst_busy_async", 64'(o_busy), 64'd0);
        i_miss = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        fillSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (o_fill_valid === 1'b1) fillSeen++;
        end
        checkOutput("rst_no_fill", 64'(fillSeen), 64'd0);
        checkOutput("rst_idle", 64'(o_busy), 64'd0);
        checkCounters("rst", 0, 0);

        // Spurious ack while idle
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h1111_1111;
        @(negedge clk);
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        checkOutput("spurious_busy", 64'(o_busy), 64'd0);
        checkOutput("spurious_req", 64'(o_mem_req), 64'd0);
        checkOutput("spurious_fill", 64'(o_fill_valid), 64'd0);

        // Back-to-back misses: second address presented during the first fetch
        fillSeen = 0;
        applyStimulus(32'h0040_0080, 1'b0, 1'b0, 18'h0, 32'h0);
        expectRequest("b2b_a", 5, waited);
        applyStimulus(32'h0080_0100, 1'b0, 1'b0, 18'h0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_frozen_addr", 64'(o_mem_addr), 64'(lineAddr(32'h0040_0080)));
        serveAck(1, 32'hAAAA_0001, 1'b1);
        expectFill("b2b_a", 5);
        if (o_fill_valid === 1'b1) fillSeen++;
        @(negedge clk);
        checkOutput("b2b_gap_busy", 64'(o_busy), 64'd0);
        expectRequest("b2b_b", 5, waited);
        checkOutput("b2b_b_latency", 64'(waited), 64'd1);
        serveAck(0, 32'hBBBB_0002, 1'b1);
        expectFill("b2b_b", 5);
        if (o_fill_valid === 1'b1) fillSeen++;
        i_miss = 1'b0;
        @(negedge clk);
        checkOutput("b2b_fill_count", 64'(fillSeen), 64'd2);
        checkOutput("b2b_busy_low", 64'(o_busy), 64'd0);
        checkCounters("b2b", 2, 0);
        checkOutput("queues_drained", 64'(reqQ.size() + fillQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
